// File: rtl/namco108_bank_unit.sv
// Namco-108 bank register file with selectable CHR layout, optional A12 scanline IRQ
// counter and a byte-wide save-state port.
module namco108_bank_unit #(
   parameter int unsigned PRG_W    = 6,
   parameter int unsigned CHR_W    = 6,
   parameter int unsigned CHR_MODE = 0,
   parameter int unsigned IRQ_EN   = 0,
   parameter int unsigned FILT     = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             wr_stb,
   input  logic [2:0]       wr_addr,
   input  logic [7:0]       wr_dat,
   input  logic [1:0]       cpu_a,
   input  logic [2:0]       ppu_a,
   output logic [PRG_W-1:0] prg_bank,
   output logic [CHR_W-1:0] chr_bank,
   output logic             irq,
   input  logic             ss_we,
   input  logic [7:0]       ss_addr,
   input  logic [7:0]       ss_din,
   output logic [7:0]       ss_dout
);

   localparam int unsigned FW = $clog2(FILT + 1);

   logic [7:0]    r_q [8];
   logic [7:0]    r_d [8];
   logic [2:0]    idx_q, idx_d;
   logic [7:0]    latch_q, latch_d;
   logic [7:0]    cnt_q, cnt_d;
   logic          reload_q, reload_d;
   logic          en_q, en_d;
   logic          pend_q, pend_d;
   logic [FW-1:0] filt_q, filt_d;
   logic          a12_q;
   logic          edge_c;
   logic [7:0]    cnt_new;
   logic [2:0]    chr_sel;

   // Next-state: save-state writes override CPU writes and suppress edge handling
   always_comb begin
      r_d      = r_q;
      idx_d    = idx_q;
      latch_d  = latch_q;
      cnt_d    = cnt_q;
      reload_d = reload_q;
      en_d     = en_q;
      pend_d   = pend_q;
      cnt_new  = cnt_q;
      filt_d   = ppu_a[2] ? '0 : ((filt_q == FW'(FILT)) ? filt_q : filt_q + FW'(1));
      edge_c   = ppu_a[2] && !a12_q && (filt_q == FW'(FILT));

      if (ss_we) begin
         if (ss_addr < 8'd8) begin
            r_d[ss_addr[2:0]] = ss_din;
         end else begin
            case (ss_addr)
               8'd8:    idx_d = ss_din[2:0];
               8'd9:    latch_d = ss_din;
               8'd10:   cnt_d = ss_din;
               8'd11: begin
                  reload_d = ss_din[2];
                  pend_d   = ss_din[1];
                  en_d     = ss_din[0];
               end
               default: ;
            endcase
         end
      end else begin
         if (wr_stb) begin
            case (wr_addr)
               3'b000: idx_d = wr_dat[2:0];
               3'b001: r_d[idx_q] = wr_dat;
               3'b100: latch_d = wr_dat;
               3'b101: reload_d = 1'b1;
               3'b110: begin
                  en_d   = 1'b0;
                  pend_d = 1'b0;
               end
               3'b111: en_d = 1'b1;
               default: ;
            endcase
         end
         // Same-cycle writes are already folded into reload_d/en_d; latch uses the old value
         if (edge_c) begin
            cnt_new  = ((cnt_q == 8'd0) || reload_d) ? latch_q : cnt_q - 8'd1;
            cnt_d    = cnt_new;
            reload_d = 1'b0;
            if ((cnt_new == 8'd0) && en_d) begin
               pend_d = 1'b1;
            end
         end
      end

      if (IRQ_EN == 0) begin
         latch_d  = '0;
         cnt_d    = '0;
         reload_d = 1'b0;
         en_d     = 1'b0;
         pend_d   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 8; i++) begin
            r_q[i] <= '0;
         end
         idx_q    <= '0;
         latch_q  <= '0;
         cnt_q    <= '0;
         reload_q <= 1'b0;
         en_q     <= 1'b0;
         pend_q   <= 1'b0;
         filt_q   <= '0;
         a12_q    <= 1'b0;
      end else begin
         r_q      <= r_d;
         idx_q    <= idx_d;
         latch_q  <= latch_d;
         cnt_q    <= cnt_d;
         reload_q <= reload_d;
         en_q     <= en_d;
         pend_q   <= pend_d;
         filt_q   <= filt_d;
         a12_q    <= ppu_a[2];
      end
   end

   assign irq = pend_q;

   always_comb begin
      case (cpu_a)
         2'd0:    prg_bank = r_q[6][PRG_W-1:0];
         2'd1:    prg_bank = r_q[7][PRG_W-1:0];
         2'd2:    prg_bank = {{(PRG_W-1){1'b1}}, 1'b0};
         default: prg_bank = '1;
      endcase
   end

   // CHR window select; 2KB windows take the low address bit from ppu_a[0]
   always_comb begin
      chr_sel  = 3'd0;
      chr_bank = '0;
      if (CHR_MODE == 0) begin
         chr_sel  = 3'd2 + 3'(ppu_a[2:1]);
         chr_bank = {r_q[chr_sel][CHR_W-2:0], ppu_a[0]};
      end else if (!ppu_a[2]) begin
         chr_sel  = 3'(ppu_a[1]);
         chr_bank = {r_q[chr_sel][CHR_W-1:1], ppu_a[0]};
      end else begin
         chr_sel  = 3'd2 + 3'(ppu_a[1:0]);
         chr_bank = r_q[chr_sel][CHR_W-1:0];
      end
   end

   always_comb begin
      ss_dout = 8'hFF;
      if (ss_addr < 8'd8) begin
         ss_dout = r_q[ss_addr[2:0]];
      end else begin
         case (ss_addr)
            8'd8:    ss_dout = {5'b0, idx_q};
            8'd9:    ss_dout = latch_q;
            8'd10:   ss_dout = cnt_q;
            8'd11:   ss_dout = {5'b0, reload_q, pend_q, en_q};
            default: ss_dout = 8'hFF;
         endcase
      end
   end

endmodule

// File: tb/tb_namco108_bank_unit.sv
// Bench for namco108_bank_unit: u0 is CHR mode 0 with IRQ logic, u1 is CHR mode 1 without it.
module tb_namco108_bank_unit;

   localparam int PRG_W = 6;
   localparam int CHR_W = 6;
   localparam int FILT  = 8;

   logic       clk = 1'b0;
   logic       rst, wr_stb, ss_we;
   logic [2:0] wr_addr, ppu_a;
   logic [7:0] wr_dat, ss_addr, ss_din;
   logic [1:0] cpu_a;

   logic [PRG_W-1:0] prg0, prg1;
   logic [CHR_W-1:0] chr0, chr1;
   logic             irq0, irq1;
   logic [7:0]       ss0, ss1;

   int ncmp  = 0;
   int nfail = 0;

   always #5 clk = ~clk;

   namco108_bank_unit #(.PRG_W(PRG_W), .CHR_W(CHR_W), .CHR_MODE(0), .IRQ_EN(1), .FILT(FILT)) u0 (
      .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_dat(wr_dat),
      .cpu_a(cpu_a), .ppu_a(ppu_a), .prg_bank(prg0), .chr_bank(chr0), .irq(irq0),
      .ss_we(ss_we), .ss_addr(ss_addr), .ss_din(ss_din), .ss_dout(ss0));

   namco108_bank_unit #(.PRG_W(PRG_W), .CHR_W(CHR_W), .CHR_MODE(1), .IRQ_EN(0), .FILT(FILT)) u1 (
      .clk(clk), .rst(rst), .wr_stb(wr_stb), .wr_addr(wr_addr), .wr_dat(wr_dat),
      .cpu_a(cpu_a), .ppu_a(ppu_a), .prg_bank(prg1), .chr_bank(chr1), .irq(irq1),
      .ss_we(ss_we), .ss_addr(ss_addr), .ss_din(ss_din), .ss_dout(ss1));

   // Reference model state, one slot per instance
   int mr [2][8];
   int midx [2], mlatch [2], mcnt [2], mreload [2], men [2], mpend [2], mlow [2], mprev [2];
   int mmode [2] = '{0, 1};
   int mirq  [2] = '{1, 0};

   typedef struct {
      bit rst, wr;
      int wa, wd, ca, pa, sa;
      int mask;
      int e_prg, e_chr0, e_chr1, e_irq, e_ss;
   } vec_t;

   vec_t tbl [$];

   function automatic vec_t V(bit r, bit w, int wa, int wd, int ca, int pa, int sa, int mask,
                              int ep, int ec0, int ec1, int ei, int es);
      vec_t v;
      v.rst = r; v.wr = w; v.wa = wa; v.wd = wd; v.ca = ca; v.pa = pa; v.sa = sa;
      v.mask = mask; v.e_prg = ep; v.e_chr0 = ec0; v.e_chr1 = ec1; v.e_irq = ei; v.e_ss = es;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nfail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic int exp_prg(int ca);
      int full = 1 << PRG_W;
      case (ca)
         0:       return mr[0][6] % full;
         1:       return mr[0][7] % full;
         2:       return full - 2;
         default: return full - 1;
      endcase
   endfunction

   function automatic int exp_chr(int m, int pa);
      int full = 1 << CHR_W;
      if (mmode[m] == 0) return (mr[m][2 + pa / 2] * 2 + pa % 2) % full;
      if (pa < 4) return ((mr[m][(pa / 2) % 2] / 2) * 2 + pa % 2) % full;
      return mr[m][2 + pa % 4] % full;
   endfunction

   function automatic int exp_ss(int m, int a);
      if (a < 8) return mr[m][a];
      case (a)
         8:       return midx[m];
         9:       return mlatch[m];
         10:      return mcnt[m];
         11:      return mreload[m] * 4 + mpend[m] * 2 + men[m];
         default: return 255;
      endcase
   endfunction

   // Behavioural update applied at each rising clock with the inputs then present
   task automatic model_update();
      for (int m = 0; m < 2; m++) begin
         if (rst) begin
            for (int i = 0; i < 8; i++) mr[m][i] = 0;
            midx[m] = 0; mlatch[m] = 0; mcnt[m] = 0; mreload[m] = 0;
            men[m] = 0; mpend[m] = 0; mlow[m] = 0; mprev[m] = 0;
         end else begin
            int  a12     = int'(ppu_a[2]);
            bit  counted = (mirq[m] == 1) && (a12 == 1) && (mprev[m] == 0) && (mlow[m] >= FILT) && !ss_we;
            int  old_lat = mlatch[m];
            int  rel     = mreload[m];
            int  en      = men[m];
            bit  dis     = 0;
            mlow[m]  = (a12 == 1) ? 0 : ((mlow[m] < 1000) ? mlow[m] + 1 : mlow[m]);
            mprev[m] = a12;
            if (ss_we) begin
               if (ss_addr < 8) mr[m][ss_addr] = int'(ss_din);
               else if (ss_addr == 8) midx[m] = ss_din % 8;
               else if (mirq[m] == 1 && ss_addr == 9) mlatch[m] = int'(ss_din);
               else if (mirq[m] == 1 && ss_addr == 10) mcnt[m] = int'(ss_din);
               else if (mirq[m] == 1 && ss_addr == 11) begin
                  mreload[m] = int'(ss_din[2]); mpend[m] = int'(ss_din[1]); men[m] = int'(ss_din[0]);
               end
            end else begin
               if (wr_stb) begin
                  if (wr_addr == 0) midx[m] = wr_dat % 8;
                  else if (wr_addr == 1) mr[m][midx[m]] = int'(wr_dat);
                  else if (mirq[m] == 1 && wr_addr == 4) mlatch[m] = int'(wr_dat);
                  else if (mirq[m] == 1 && wr_addr == 5) rel = 1;
                  else if (mirq[m] == 1 && wr_addr == 6) begin en = 0; dis = 1; end
                  else if (mirq[m] == 1 && wr_addr == 7) en = 1;
               end
               if (counted) begin
                  if (mcnt[m] == 0 || rel == 1) mcnt[m] = old_lat;
                  else mcnt[m] = mcnt[m] - 1;
                  rel = 0;
                  if (mcnt[m] == 0 && en == 1) mpend[m] = 1;
               end
               if (dis) mpend[m] = 0;
               mreload[m] = rel;
               men[m]     = en;
            end
         end
      end
   endtask

   task automatic check_model();
      chk("u0.prg", 32'(prg0), 32'(exp_prg(int'(cpu_a))));
      chk("u0.chr", 32'(chr0), 32'(exp_chr(0, int'(ppu_a))));
      chk("u1.chr", 32'(chr1), 32'(exp_chr(1, int'(ppu_a))));
      chk("u0.irq", 32'(irq0), 32'(mpend[0]));
      chk("u1.irq", 32'(irq1), 32'(mpend[1]));
      chk("u0.ss",  32'(ss0),  32'(exp_ss(0, int'(ss_addr))));
      chk("u1.ss",  32'(ss1),  32'(exp_ss(1, int'(ss_addr))));
   endtask

   task automatic step_v(input vec_t v);
      @(negedge clk);
      if (v.mask[0]) chk("tbl.prg0", 32'(prg0), 32'(v.e_prg));
      if (v.mask[1]) chk("tbl.chr0", 32'(chr0), 32'(v.e_chr0));
      if (v.mask[2]) chk("tbl.chr1", 32'(chr1), 32'(v.e_chr1));
      if (v.mask[3]) chk("tbl.irq0", 32'(irq0), 32'(v.e_irq));
      if (v.mask[4]) chk("tbl.ss0",  32'(ss0),  32'(v.e_ss));
      check_model();
      @(posedge clk);
      model_update();
      #1;
   endtask

   task automatic step();
      step_v(V(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
   endtask

   task automatic wr(input int a, input int d);
      wr_stb = 1'b1; wr_addr = 3'(a); wr_dat = 8'(d);
      step();
      wr_stb = 1'b0;
   endtask

   // lows cycles of A12 low, then one high cycle carrying an optional write (wa >= 0)
   task automatic rise(input int lows, input int wa, input int wd);
      ppu_a = 3'b000;
      for (int i = 0; i < lows; i++) step();
      ppu_a = 3'b100;
      if (wa >= 0) begin
         wr_stb = 1'b1; wr_addr = 3'(wa); wr_dat = 8'(wd);
      end
      step();
      wr_stb = 1'b0;
      ppu_a  = 3'b000;
   endtask

   task automatic peek(input int m, input int a, input int e, input string nm);
      ss_addr = 8'(a);
      #1;
      chk(nm, (m == 0) ? 32'(ss0) : 32'(ss1), 32'(e));
   endtask

   initial begin
      int low_left;
      bit a12;
      rst = 1'b1; wr_stb = 1'b0; wr_addr = '0; wr_dat = '0; cpu_a = '0; ppu_a = '0;
      ss_we = 1'b0; ss_addr = '0; ss_din = '0;
      for (int m = 0; m < 2; m++) begin
         for (int i = 0; i < 8; i++) mr[m][i] = 0;
         midx[m] = 0; mlatch[m] = 0; mcnt[m] = 0; mreload[m] = 0;
         men[m] = 0; mpend[m] = 0; mlow[m] = 0; mprev[m] = 0;
      end
      @(posedge clk); #1;

      // rst wr wa wd ca pa sa mask prg chr0 chr1 irq ss
      tbl.push_back(V(1, 0, 0, 0,     0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 0, 0,   31, 0,    0,    0,    0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 0, 11,  16, 0,    0,    0,    0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 0, 12,  16, 0,    0,    0,    0, 255));
      tbl.push_back(V(0, 1, 0, 2,     0, 0, 8,   16, 0,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 1, 'h15,  0, 0, 8,   16, 0,    0,    0,    0, 2));
      tbl.push_back(V(0, 0, 0, 0,     0, 0, 2,   22, 0,    'h2A, 0,    0, 'h15));
      tbl.push_back(V(0, 0, 0, 0,     0, 1, 2,   6,  0,    'h2B, 'h01, 0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 4, 0,   6,  0,    0,    'h15, 0, 0));
      tbl.push_back(V(0, 1, 0, 6,     0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 1, 3,     0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 0, 7,     0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 1, 9,     0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 3, 'h55,  0, 0, 0,   1,  3,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 2, 'hAA,  1, 0, 7,   17, 9,    0,    0,    0, 9));
      tbl.push_back(V(0, 0, 0, 0,     2, 0, 7,   17, 'h3E, 0,    0,    0, 9));
      tbl.push_back(V(0, 0, 0, 0,     3, 0, 0,   1,  'h3F, 0,    0,    0, 0));
      tbl.push_back(V(0, 1, 0, 0,     0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 1, 'h11,  0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 0, 2,     0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 1, 1, 7,     0, 0, 0,   0,  0,    0,    0,    0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 0, 0,   6,  0,    'h0E, 'h10, 0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 1, 0,   6,  0,    'h0F, 'h11, 0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 4, 0,   6,  0,    0,    'h07, 0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 5, 0,   6,  0,    1,    0,    0, 0));
      tbl.push_back(V(0, 0, 0, 0,     0, 6, 0,   2,  0,    0,    0,    0, 0));

      for (int i = 0; i < tbl.size(); i++) begin
         rst = tbl[i].rst; wr_stb = tbl[i].wr; wr_addr = 3'(tbl[i].wa); wr_dat = 8'(tbl[i].wd);
         cpu_a = 2'(tbl[i].ca); ppu_a = 3'(tbl[i].pa); ss_addr = 8'(tbl[i].sa);
         step_v(tbl[i]);
      end
      rst = 1'b0; wr_stb = 1'b0; ppu_a = 3'b000; cpu_a = 2'd0;

      // Scanline counter: latch=2, reload, enable, three filtered rises
      rst = 1'b1; step(); rst = 1'b0;
      wr(4, 2); wr(5, 0); wr(7, 0);
      rise(FILT, -1, 0); peek(0, 10, 2, "irq.cnt2"); chk("irq.low2", 32'(irq0), 32'd0);
      rise(FILT, -1, 0); peek(0, 10, 1, "irq.cnt1"); chk("irq.low1", 32'(irq0), 32'd0);
      rise(FILT, -1, 0); peek(0, 10, 0, "irq.cnt0"); chk("irq.set", 32'(irq0), 32'd1);
      chk("u1.irq.off", 32'(irq1), 32'd0);
      peek(0, 11, 3, "irq.flags");
      peek(1, 9, 0, "u1.latch.off");
      wr(6, 0); chk("irq.clr", 32'(irq0), 32'd0);

      // Filter boundary: FILT-1 lows ignored, FILT lows counted
      wr(4, 3); wr(5, 0);
      rise(FILT, -1, 0);     peek(0, 10, 3, "filt.load");
      rise(FILT - 1, -1, 0); peek(0, 10, 3, "filt.short");
      rise(FILT, -1, 0);     peek(0, 10, 2, "filt.full");

      // Edge coincident with disable: pending never appears
      wr(7, 0); wr(4, 1); wr(5, 0);
      rise(FILT, -1, 0); peek(0, 10, 1, "dis.cnt1");
      rise(FILT, 6, 0);  chk("dis.irq", 32'(irq0), 32'd0);
      peek(0, 11, 0, "dis.flags"); peek(0, 10, 0, "dis.cnt0");

      // Edge coincident with reload while cnt=5
      wr(4, 5); wr(5, 0);
      rise(FILT, -1, 0); peek(0, 10, 5, "rel.cnt5");
      wr(4, 9);
      rise(FILT, 5, 0);  peek(0, 10, 9, "rel.cnt");  peek(0, 11, 0, "rel.flags");

      // Edge coincident with enable reaching zero
      wr(4, 1); wr(5, 0);
      rise(FILT, -1, 0); peek(0, 10, 1, "en.cnt1");
      rise(FILT, 7, 0);  chk("en.irq", 32'(irq0), 32'd1);
      wr(6, 0);

      // Save-state write, priority over a same-cycle CPU write
      ss_we = 1'b1; ss_addr = 8'd10; ss_din = 8'd1; step(); ss_we = 1'b0;
      peek(0, 10, 1, "ss.cnt");
      ss_we = 1'b1; ss_addr = 8'd9; ss_din = 8'h40;
      wr_stb = 1'b1; wr_addr = 3'd4; wr_dat = 8'h22; step();
      ss_we = 1'b0; wr_stb = 1'b0;
      peek(0, 9, 'h40, "ss.prio");

      // Reset mid-count with IRQ pending and filter partly counted
      wr(0, 3); wr(1, 'h5A); wr(7, 0); wr(4, 1); wr(5, 0);
      rise(FILT, -1, 0); rise(FILT, -1, 0);
      chk("rst.pre", 32'(irq0), 32'd1);
      for (int i = 0; i < 5; i++) step();
      rst = 1'b1; step(); rst = 1'b0;
      chk("rst.irq", 32'(irq0), 32'd0);
      for (int a = 0; a < 12; a++) peek(0, a, 0, "rst.ss");

      // Randomised run against the model
      low_left = 0; a12 = 1'b0;
      for (int n = 0; n < 4000; n++) begin
         if (low_left == 0) begin
            a12 = ~a12;
            low_left = a12 ? int'($urandom_range(1, 3)) : int'($urandom_range(FILT - 2, FILT + 2));
         end
         low_left--;
         rst     = ($urandom % 400) == 0;
         wr_stb  = ($urandom % 4) == 0;
         wr_addr = 3'($urandom % 8);
         wr_dat  = (wr_addr == 3'd4) ? 8'($urandom % 4) : 8'($urandom);
         cpu_a   = 2'($urandom);
         ppu_a   = {a12, 2'($urandom)};
         ss_we   = ($urandom % 40) == 0;
         ss_addr = ss_we ? 8'($urandom % 14) : 8'($urandom % 16);
         ss_din  = 8'($urandom);
         step();
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
